writeback_stage: RTL and testbench

- Write end of the register-file interface. Holds the M→W pipeline register and drives the W_dstE/W_valE/W_dstM/W_valM write port consumed by decode's register file and forwarding logic.
- Owns program status. On a halt, address fault, or illegal instruction it suppresses writes, runs a drain countdown, then raises a sticky done that triggers the register dump.
- Keeps retired-instruction and cycle counters for CPI measurement.

---
 rtl/writeback_stage.sv | 174 +++++++++++++++++
 tb/tb_writeback_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: M->W pipeline register, gated register-file write port,
// program status with drain/done sequencing, and retire/cycle counters.
module writeback_stage #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [2:0]       M_stat_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       M_dstE_i,
  input  logic [3:0]       M_dstM_i,
  input  logic [63:0]      M_valE_i,
  input  logic [63:0]      m_valM_i,
  input  logic             W_stall_i,
  input  logic             W_bubble_i,
  output logic [2:0]       W_stat_o,
  output logic [3:0]       W_icode_o,
  output logic [3:0]       W_dstE_o,
  output logic [63:0]      W_valE_o,
  output logic [3:0]       W_dstM_o,
  output logic [63:0]      W_valM_o,
  output logic [2:0]       stat_o,
  output logic             done_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [2:0] SHLT  = 3'd2;
  localparam logic [2:0] SADR  = 3'd3;
  localparam logic [2:0] SINS  = 3'd4;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  logic             valid_q, valid_d;
  logic [2:0]       wstat_q, wstat_d;
  logic [3:0]       icode_q, icode_d;
  logic [3:0]       dstE_q, dstE_d;
  logic [3:0]       dstM_q, dstM_d;
  logic [63:0]      valE_q, valE_d;
  logic [63:0]      valM_q, valM_d;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic             term;
  logic             wr_en;

  assign term  = valid_q &&
                 ((wstat_q == SHLT) ||
                  (wstat_q == SADR) ||
                  (wstat_q == SINS));
  assign wr_en = (state_q == RUN) && (wstat_q == SAOK);

  // Bubble wins over stall so control can squash a held slot.
  always_comb begin
    valid_d = valid_q;
    wstat_d = wstat_q;
    icode_d = icode_q;
    dstE_d  = dstE_q;
    dstM_d  = dstM_q;
    valE_d  = valE_q;
    valM_d  = valM_q;
    if (W_bubble_i) begin
      valid_d = 1'b0;
      wstat_d = SAOK;
      icode_d = INOP;
      dstE_d  = RNONE;
      dstM_d  = RNONE;
      valE_d  = '0;
      valM_d  = '0;
    end else if (!W_stall_i) begin
      valid_d = 1'b1;
      wstat_d = M_stat_i;
      icode_d = M_icode_i;
      dstE_d  = M_dstE_i;
      dstM_d  = M_dstM_i;
      valE_d  = M_valE_i;
      valM_d  = m_valM_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    stat_d  = stat_q;
    ret_d   = ret_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (valid_q && (wstat_q == SAOK))
          ret_d = ret_q + 1'b1;
        if (term) begin
          stat_d = wstat_q;
          if (DRAIN_CYCLES <= 1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      DRAIN: begin
        // Done rises on the edge the count runs out.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      wstat_q <= SAOK;
      icode_q <= INOP;
      dstE_q  <= RNONE;
      dstM_q  <= RNONE;
      valE_q  <= '0;
      valM_q  <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      stat_q  <= SAOK;
      ret_q   <= '0;
      cyc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wstat_q <= wstat_d;
      icode_q <= icode_d;
      dstE_q  <= dstE_d;
      dstM_q  <= dstM_d;
      valE_q  <= valE_d;
      valM_q  <= valM_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      stat_q  <= stat_d;
      ret_q   <= ret_d;
      cyc_q   <= cyc_d;
    end
  end

  assign W_stat_o  = wstat_q;
  assign W_icode_o = icode_q;
  assign W_dstE_o  = wr_en ? dstE_q : RNONE;
  assign W_dstM_o  = wr_en ? dstM_q : RNONE;
  assign W_valE_o  = valE_q;
  assign W_valM_o  = valM_q;
  assign stat_o    = stat_q;
  assign done_o    = done_q;
  assign retired_o = ret_q;
  assign cycles_o  = cyc_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, a short hand sequence,
// then random traffic against a status/age reference model.
module tb_writeback_stage;

  localparam int DRAIN = 2;

  logic        clk = 0;
  logic        rst_n;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, m_valM;
  logic        stall, bubble;
  logic [2:0]  W_stat, stat;
  logic [3:0]  W_icode, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic        done;
  logic [31:0] retired, cycles;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_stage #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .M_stat_i(M_stat), .M_icode_i(M_icode),
    .M_dstE_i(M_dstE), .M_dstM_i(M_dstM),
    .M_valE_i(M_valE), .m_valM_i(m_valM),
    .W_stall_i(stall), .W_bubble_i(bubble),
    .W_stat_o(W_stat), .W_icode_o(W_icode),
    .W_dstE_o(W_dstE), .W_valE_o(W_valE),
    .W_dstM_o(W_dstM), .W_valM_o(W_valM),
    .stat_o(stat), .done_o(done),
    .retired_o(retired), .cycles_o(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] s,
                       input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve,
                       input logic [63:0] vm, input logic st,
                       input logic bu);
    rst_n = r; M_stat = s; M_icode = ic; M_dstE = de; M_dstM = dm;
    M_valE = ve; m_valM = vm; stall = st; bubble = bu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [2:0]  s;
    logic [3:0]  ic, de, dm;
    logic [63:0] ve, vm;
    logic        st, bu;
    logic [3:0]  x_de, x_dm;
    logic [63:0] x_ve, x_vm;
    logic [2:0]  x_stat;
    logic        x_done;
    logic [31:0] x_ret, x_cyc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic r, logic [2:0] s, logic [3:0] ic, logic [3:0] de,
    logic [3:0] dm, logic [63:0] ve, logic [63:0] vm, logic st,
    logic bu, logic [3:0] x_de, logic [63:0] x_ve, logic [3:0] x_dm,
    logic [63:0] x_vm, logic [2:0] x_stat, logic x_done,
    logic [31:0] x_ret, logic [31:0] x_cyc);
    vec_t v;
    v.r = r; v.s = s; v.ic = ic; v.de = de; v.dm = dm;
    v.ve = ve; v.vm = vm; v.st = st; v.bu = bu;
    v.x_de = x_de; v.x_ve = x_ve; v.x_dm = x_dm; v.x_vm = x_vm;
    v.x_stat = x_stat; v.x_done = x_done;
    v.x_ret = x_ret; v.x_cyc = x_cyc;
    return v;
  endfunction

  // Reference model: W contents plus "edges since the terminating
  // instruction reached W" (0 = still running).
  typedef struct {
    logic        valid;
    logic [2:0]  s;
    logic [3:0]  ic, de, dm;
    logic [63:0] ve, vm;
  } w_t;

  w_t          mw;
  int          age;
  logic [2:0]  mstat;
  logic [31:0] mret, mcyc;

  function automatic w_t bub();
    w_t b;
    b.valid = 0; b.s = 1; b.ic = 1; b.de = 4'hF; b.dm = 4'hF;
    b.ve = 0; b.vm = 0;
    return b;
  endfunction

  task automatic model_edge();
    w_t n;
    if (!rst_n) begin
      mw = bub(); age = 0; mstat = 1; mret = 0; mcyc = 0;
      return;
    end
    if (age == 0) begin
      mcyc = mcyc + 1;
      if (mw.valid && mw.s == 1) mret = mret + 1;
      if (mw.valid && mw.s >= 2 && mw.s <= 4) begin
        age = 1;
        mstat = mw.s;
      end
    end else if (age < 100) begin
      age++;
    end
    if (bubble) mw = bub();
    else if (!stall) begin
      n.valid = 1; n.s = M_stat; n.ic = M_icode; n.de = M_dstE;
      n.dm = M_dstM; n.ve = M_valE; n.vm = m_valM;
      mw = n;
    end
  endtask

  task automatic model_check();
    logic wr;
    wr = (age == 0) && (mw.s == 1);
    chk("W_stat", W_stat, mw.s);
    chk("W_icode", W_icode, mw.ic);
    chk("W_dstE", W_dstE, wr ? mw.de : 4'hF);
    chk("W_dstM", W_dstM, wr ? mw.dm : 4'hF);
    chk("W_valE", W_valE, mw.ve);
    chk("W_valM", W_valM, mw.vm);
    chk("stat", stat, mstat);
    chk("done", done, age >= DRAIN);
    chk("retired", retired, mret);
    chk("cycles", cycles, mcyc);
  endtask

  initial begin
    drive(0, 1, 1, 4'hF, 4'hF, 0, 0, 0, 0);

    // Directed vectors: outputs are checked after each applied edge.
    //          r s ic de    dm    valE   valM    st bu  xdE   xvE    xdM   xvM     st dn ret cyc
    vt.push_back(mk(0,1,1,4'hF,4'hF,0,     0,      0,0, 4'hF, 0,     4'hF, 0,      1,0, 0, 0));
    vt.push_back(mk(0,1,1,4'hF,4'hF,0,     0,      0,0, 4'hF, 0,     4'hF, 0,      1,0, 0, 0));
    vt.push_back(mk(1,1,6,4'h2,4'hF,'h1234,0,      0,0, 4'h2, 'h1234,4'hF, 0,      1,0, 0, 1));
    vt.push_back(mk(1,1,'hB,4'h4,4'h0,'h200,'hABCD,0,0, 4'h4, 'h200, 4'h0, 'hABCD, 1,0, 1, 2));
    vt.push_back(mk(1,1,2,4'h3,4'hF,'h55,  0,      0,0, 4'h3, 'h55,  4'hF, 0,      1,0, 2, 3));
    vt.push_back(mk(1,1,6,4'h7,4'hF,'h99,  0,      1,0, 4'h3, 'h55,  4'hF, 0,      1,0, 3, 4));
    vt.push_back(mk(1,1,6,4'h7,4'hF,'h99,  0,      1,0, 4'h3, 'h55,  4'hF, 0,      1,0, 4, 5));
    vt.push_back(mk(1,1,6,4'h7,4'hF,'h99,  0,      1,0, 4'h3, 'h55,  4'hF, 0,      1,0, 5, 6));
    vt.push_back(mk(1,1,6,4'h7,4'hF,'h99,  0,      1,1, 4'hF, 0,     4'hF, 0,      1,0, 6, 7));
    vt.push_back(mk(1,2,0,4'h6,4'hF,'h77,  0,      0,0, 4'hF, 'h77,  4'hF, 0,      1,0, 6, 8));
    vt.push_back(mk(1,1,6,4'h2,4'hF,'h11,  0,      0,0, 4'hF, 'h11,  4'hF, 0,      2,0, 6, 9));
    vt.push_back(mk(1,1,6,4'h3,4'hF,'h22,  0,      0,0, 4'hF, 'h22,  4'hF, 0,      2,1, 6, 9));
    vt.push_back(mk(1,1,6,4'h4,4'hF,'h33,  0,      0,0, 4'hF, 'h33,  4'hF, 0,      2,1, 6, 9));
    vt.push_back(mk(0,1,1,4'hF,4'hF,0,     0,      0,0, 4'hF, 0,     4'hF, 0,      1,0, 0, 0));
    vt.push_back(mk(1,3,5,4'h5,4'hF,'h44,  0,      0,0, 4'hF, 'h44,  4'hF, 0,      1,0, 0, 1));
    vt.push_back(mk(1,1,6,4'h1,4'hF,'h66,  0,      0,0, 4'hF, 'h66,  4'hF, 0,      3,0, 0, 2));
    vt.push_back(mk(0,1,6,4'h1,4'hF,'h66,  0,      0,0, 4'hF, 0,     4'hF, 0,      1,0, 0, 0));
    vt.push_back(mk(1,1,6,4'h9,4'hF,'h88,  0,      0,0, 4'h9, 'h88,  4'hF, 0,      1,0, 0, 1));

    foreach (vt[i]) begin
      vec_t v;
      string p;
      v = vt[i];
      drive(v.r, v.s, v.ic, v.de, v.dm, v.ve, v.vm, v.st, v.bu);
      tick();
      p = $sformatf("vec%0d", i);
      chk({p, ".dstE"}, W_dstE, v.x_de);
      chk({p, ".valE"}, W_valE, v.x_ve);
      chk({p, ".dstM"}, W_dstM, v.x_dm);
      chk({p, ".valM"}, W_valM, v.x_vm);
      chk({p, ".stat"}, stat, v.x_stat);
      chk({p, ".done"}, done, v.x_done);
      chk({p, ".retired"}, retired, v.x_ret);
      chk({p, ".cycles"}, cycles, v.x_cyc);
    end

    // Same index on both ports is still driven on both.
    drive(1, 1, 'hB, 4'h5, 4'h5, 'hA, 'hB, 0, 0);
    tick();
    chk("dup.dstE", W_dstE, 4'h5);
    chk("dup.dstM", W_dstM, 4'h5);
    // Illegal instruction: done on the second edge, not the first.
    drive(1, 4, 0, 4'h2, 4'h3, 0, 0, 0, 0);
    tick();
    chk("ins.dstM", W_dstM, 4'hF);
    chk("ins.stat_w", W_stat, 3'd4);
    drive(1, 1, 6, 4'h2, 4'hF, 0, 0, 0, 0);
    tick();
    chk("ins.done1", done, 1'b0);
    chk("ins.stat", stat, 3'd4);
    tick();
    chk("ins.done2", done, 1'b1);
    chk("ins.cycles", cycles, 32'd4);

    // Randomised traffic against the model.
    drive(0, 1, 1, 4'hF, 4'hF, 0, 0, 0, 0);
    model_edge();
    tick();
    model_check();
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      drive($urandom_range(0, 99) >= 2,
            (r < 3) ? 3'($urandom_range(2, 4)) : 3'd1,
            4'($urandom), 4'($urandom), 4'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
      model_edge();
      tick();
      model_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
